// File: rtl/store_pkg.sv
// Shared constants and types for the store data unit: func3 encodings,
// FSM state encoding, queue entry layout and default queue depth.
package store_pkg;

   localparam logic [2:0] SB = 3'b000;
   localparam logic [2:0] SH = 3'b001;
   localparam logic [2:0] SW = 3'b010;

   localparam int DEFAULT_DEPTH = 2;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  byteen;
   } entry_t;

   function automatic logic is_legal(input logic [2:0] f);
      return (f == SB) || (f == SH) || (f == SW);
   endfunction

endpackage

// File: rtl/store_data_unit_if.sv
// Store request and memory write bundle between the MEM stage, the store
// data unit and the data memory.
interface store_data_unit_if;

   logic        st_valid;
   logic [2:0]  func3;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        st_stall;
   logic        misalign_err;

   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_byteen;
   logic        mem_busywait;

   modport master (
      output st_valid, func3, st_addr, st_data, mem_busywait,
      input  st_stall, misalign_err, mem_write, mem_addr, mem_wdata, mem_byteen
   );

   modport slave (
      input  st_valid, func3, st_addr, st_data, mem_busywait,
      output st_stall, misalign_err, mem_write, mem_addr, mem_wdata, mem_byteen
   );

endinterface

// File: rtl/store_lane_formatter.sv
// Combinational store formatter: word address, lane placement, byte enables,
// legality and alignment check of one store request.
module store_lane_formatter
   import store_pkg::*;
(
   input  logic [2:0]  func3,
   input  logic [31:0] addr,
   input  logic [31:0] data,
   output logic        legal,
   output logic        misaligned,
   output entry_t      entry
);

   always_comb begin
      legal        = 1'b0;
      misaligned   = 1'b0;
      entry.addr   = {addr[31:2], 2'b00};
      entry.wdata  = 32'h0;
      entry.byteen = 4'b0000;
      case (func3)
         SB: begin
            legal        = 1'b1;
            entry.byteen = 4'b0001 << addr[1:0];
            entry.wdata  = {24'h0, data[7:0]} << {addr[1:0], 3'b000};
         end
         SH: begin
            legal      = 1'b1;
            misaligned = addr[0];
            if (addr[1]) begin
               entry.byteen = 4'b1100;
               entry.wdata  = {data[15:0], 16'h0};
            end else begin
               entry.byteen = 4'b0011;
               entry.wdata  = {16'h0, data[15:0]};
            end
         end
         SW: begin
            legal        = 1'b1;
            misaligned   = (addr[1:0] != 2'b00);
            entry.byteen = 4'b1111;
            entry.wdata  = data;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/store_data_unit.sv
// Store data unit: formats MEM-stage stores into a DEPTH-entry FIFO and
// drains it to data memory one word write at a time.
module store_data_unit
   import store_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
)(
   input  logic CLK,
   input  logic RESET,
   store_data_unit_if.slave bus
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             legal;
   logic             misaligned;
   entry_t           fmt;
   entry_t           q [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             full;
   logic             push;
   logic             pop;
   logic             misalign_q;
   logic             mem_write_q;
   state_t           state;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   store_lane_formatter u_fmt (
      .func3      (bus.func3),
      .addr       (bus.st_addr),
      .data       (bus.st_data),
      .legal      (legal),
      .misaligned (misaligned),
      .entry      (fmt)
   );

   // Full is taken from the registered count so a same-edge pop never frees a slot early.
   assign full       = (count == CNT_W'(DEPTH));
   assign push       = bus.st_valid & legal & ~misaligned & ~full;
   assign pop        = (state == WRITE) & ~bus.mem_busywait;
   assign count_next = count + CNT_W'(push) - CNT_W'(pop);

   assign bus.st_stall     = full;
   assign bus.misalign_err = misalign_q;
   assign bus.mem_write    = mem_write_q;
   assign bus.mem_addr     = q[rd_ptr].addr;
   assign bus.mem_wdata    = q[rd_ptr].wdata;
   assign bus.mem_byteen   = q[rd_ptr].byteen;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         misalign_q <= 1'b0;
      end else begin
         if (push) begin
            q[wr_ptr] <= fmt;
            wr_ptr    <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         count      <= count_next;
         misalign_q <= bus.st_valid & legal & misaligned;
      end
   end

   // Write FSM: mem_write is registered alongside the state so it is 1 exactly in WRITE.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state       <= IDLE;
         mem_write_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (count_next != '0) begin
                  state       <= WRITE;
                  mem_write_q <= 1'b1;
               end
            end
            WRITE: begin
               if (pop && (count_next == '0)) begin
                  state       <= IDLE;
                  mem_write_q <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               mem_write_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_store_data_unit.sv
// Directed bench for store_data_unit: table of single-store vectors plus
// hand sequences for queue-full, back-to-back and mid-write reset.
module tb_store_data_unit;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_bad;

   store_data_unit_if bus ();

   store_data_unit #(.DEPTH(2)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] data;
      logic        err;
      logic        wr;
      logic [31:0] ea;
      logic [31:0] ed;
      logic [3:0]  eb;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      bus.st_valid = v;
      bus.func3    = f3;
      bus.st_addr  = a;
      bus.st_data  = d;
   endtask

   initial begin
      tbl[0]  = '{3'b000, 32'h0000_1003, 32'hAABB_CCDD, 1'b0, 1'b1, 32'h0000_1000, 32'hDD00_0000, 4'b1000};
      tbl[1]  = '{3'b000, 32'h0000_1000, 32'hAABB_CCDD, 1'b0, 1'b1, 32'h0000_1000, 32'h0000_00DD, 4'b0001};
      tbl[2]  = '{3'b000, 32'h0000_1001, 32'hAABB_CCDD, 1'b0, 1'b1, 32'h0000_1000, 32'h0000_DD00, 4'b0010};
      tbl[3]  = '{3'b001, 32'h0000_2002, 32'h0000_1234, 1'b0, 1'b1, 32'h0000_2000, 32'h1234_0000, 4'b1100};
      tbl[4]  = '{3'b001, 32'h0000_2000, 32'hABCD_1234, 1'b0, 1'b1, 32'h0000_2000, 32'h0000_1234, 4'b0011};
      tbl[5]  = '{3'b001, 32'h0000_2001, 32'h0000_1234, 1'b1, 1'b0, 32'h0,         32'h0,         4'b0000};
      tbl[6]  = '{3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111};
      tbl[7]  = '{3'b010, 32'h0000_3002, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         32'h0,         4'b0000};
      tbl[8]  = '{3'b010, 32'h0000_3001, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         32'h0,         4'b0000};
      tbl[9]  = '{3'b011, 32'h0000_3000, 32'h1111_2222, 1'b0, 1'b0, 32'h0,         32'h0,         4'b0000};
      tbl[10] = '{3'b100, 32'h0000_3001, 32'h1111_2222, 1'b0, 1'b0, 32'h0,         32'h0,         4'b0000};
      tbl[11] = '{3'b000, 32'h0000_4002, 32'hAABB_CCDD, 1'b0, 1'b1, 32'h0000_4000, 32'h00DD_0000, 4'b0100};

      n_vec = 0;
      n_bad = 0;
      rst   = 1'b1;
      drive(1'b0, 3'b000, 32'h0, 32'h0);
      bus.mem_busywait = 1'b0;

      #2;
      chk("rst_mem_write", {31'h0, bus.mem_write}, 32'h0);
      chk("rst_stall",     {31'h0, bus.st_stall}, 32'h0);
      chk("rst_err",       {31'h0, bus.misalign_err}, 32'h0);
      chk("rst_addr",      bus.mem_addr, 32'h0);
      chk("rst_wdata",     bus.mem_wdata, 32'h0);
      chk("rst_byteen",    {28'h0, bus.mem_byteen}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Single-store table: accept, one write cycle, back to idle.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         drive(1'b1, tbl[i].f3, tbl[i].addr, tbl[i].data);
         @(negedge clk);
         drive(1'b0, 3'b000, 32'h0, 32'h0);
         chk($sformatf("v%0d_err", i),   {31'h0, bus.misalign_err}, {31'h0, tbl[i].err});
         chk($sformatf("v%0d_write", i), {31'h0, bus.mem_write},    {31'h0, tbl[i].wr});
         if (tbl[i].wr) begin
            chk($sformatf("v%0d_addr", i),   bus.mem_addr,  tbl[i].ea);
            chk($sformatf("v%0d_wdata", i),  bus.mem_wdata, tbl[i].ed);
            chk($sformatf("v%0d_byteen", i), {28'h0, bus.mem_byteen}, {28'h0, tbl[i].eb});
         end
         @(negedge clk);
         chk($sformatf("v%0d_err_off", i),   {31'h0, bus.misalign_err}, 32'h0);
         chk($sformatf("v%0d_write_off", i), {31'h0, bus.mem_write}, 32'h0);
      end

      // Fill the queue under busywait, third store stalls; release while still full.
      @(negedge clk);
      bus.mem_busywait = 1'b1;
      drive(1'b1, 3'b010, 32'h0000_0100, 32'h1111_1111);
      @(negedge clk);
      chk("full_stall0", {31'h0, bus.st_stall}, 32'h0);
      chk("full_write0", {31'h0, bus.mem_write}, 32'h1);
      drive(1'b1, 3'b010, 32'h0000_0104, 32'h2222_2222);
      @(negedge clk);
      chk("full_stall1", {31'h0, bus.st_stall}, 32'h1);
      chk("full_head0",  bus.mem_addr, 32'h0000_0100);
      drive(1'b1, 3'b010, 32'h0000_0108, 32'h3333_3333);
      @(negedge clk);
      chk("full_stall2", {31'h0, bus.st_stall}, 32'h1);
      chk("full_hold",   bus.mem_addr, 32'h0000_0100);
      chk("full_hold_d", bus.mem_wdata, 32'h1111_1111);
      bus.mem_busywait = 1'b0;
      @(negedge clk);
      drive(1'b0, 3'b000, 32'h0, 32'h0);
      chk("drain_write1", {31'h0, bus.mem_write}, 32'h1);
      chk("drain_addr1",  bus.mem_addr, 32'h0000_0104);
      chk("drain_data1",  bus.mem_wdata, 32'h2222_2222);
      chk("drain_stall",  {31'h0, bus.st_stall}, 32'h0);
      @(negedge clk);
      chk("drain_idle0", {31'h0, bus.mem_write}, 32'h0);
      @(negedge clk);
      chk("drain_idle1", {31'h0, bus.mem_write}, 32'h0);

      // Enqueue and completion on the same edge keep writing without a gap.
      drive(1'b1, 3'b010, 32'h0000_0200, 32'hAAAA_0001);
      @(negedge clk);
      chk("b2b_write0", {31'h0, bus.mem_write}, 32'h1);
      chk("b2b_addr0",  bus.mem_addr, 32'h0000_0200);
      drive(1'b1, 3'b010, 32'h0000_0204, 32'hAAAA_0002);
      @(negedge clk);
      drive(1'b0, 3'b000, 32'h0, 32'h0);
      chk("b2b_write1", {31'h0, bus.mem_write}, 32'h1);
      chk("b2b_addr1",  bus.mem_addr, 32'h0000_0204);
      chk("b2b_data1",  bus.mem_wdata, 32'hAAAA_0002);
      chk("b2b_stall",  {31'h0, bus.st_stall}, 32'h0);
      @(negedge clk);
      chk("b2b_idle", {31'h0, bus.mem_write}, 32'h0);

      // Reset during a write with two stores queued.
      bus.mem_busywait = 1'b1;
      drive(1'b1, 3'b010, 32'h0000_0300, 32'h5555_5555);
      @(negedge clk);
      drive(1'b1, 3'b010, 32'h0000_0304, 32'h6666_6666);
      @(negedge clk);
      drive(1'b0, 3'b000, 32'h0, 32'h0);
      chk("rstw_write", {31'h0, bus.mem_write}, 32'h1);
      chk("rstw_stall", {31'h0, bus.st_stall}, 32'h1);
      rst = 1'b1;
      #1;
      chk("rstw_write_off", {31'h0, bus.mem_write}, 32'h0);
      chk("rstw_stall_off", {31'h0, bus.st_stall}, 32'h0);
      chk("rstw_addr",      bus.mem_addr, 32'h0);
      chk("rstw_byteen",    {28'h0, bus.mem_byteen}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      bus.mem_busywait = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("rstw_after%0d", k), {31'h0, bus.mem_write}, 32'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
